// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display with blanking gaps.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int MAX_N = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      value_q, value_d;
    logic [3:0]       dp_mask_q, dp_mask_d;
    logic [3:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] d);
        case (d)
            2'd3:    return v[15:12] == 4'h0;
            2'd2:    return v[15:8] == 8'h00;
            2'd1:    return v[15:4] == 12'h000;
            default: return 1'b0;
        endcase
    endfunction
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        state_d      = state_q;
        counter_d    = counter_q + 1'b1;
        digit_d      = digit_q;
        value_d      = load ? value   : value_q;
        dp_mask_d    = load ? dp_mask : dp_mask_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || counter_q == BLANK_LAST) begin
                    state_d   = ST_SHOW;
                    counter_d = '0;
                end
            end
            default: begin
                if (counter_q == SHOW_LAST) begin
                    state_d      = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    counter_d    = '0;
                    digit_d      = digit_q - 2'd1;
                    frame_done_d = (digit_q == 2'd0);
                end
            end
        endcase

        // Outputs are registered from next-state values so they line up with the state they describe.
        anode_d = 4'b1111;
        seg_d   = 7'b1111111;
        dp_d    = 1'b1;
        if (state_d == ST_SHOW) begin
            anode_d = ~(4'b0001 << digit_d);
            seg_d   = seg_decode(value_d[{digit_d, 2'b00} +: 4]);
            dp_d    = ~dp_mask_d[digit_d];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            if (leading_zero(value_d, digit_d)) begin
                seg_d = 7'b1111111;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            counter_q    <= '0;
            digit_q      <= 2'd3;
            value_q      <= '0;
            dp_mask_q    <= '0;
            anode_q      <= 4'b1111;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            digit_q      <= digit_d;
            value_q      <= value_d;
            dp_mask_q    <= dp_mask_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: two instances (with and without blanking) checked every cycle against queued expectations.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;

    logic [3:0]  anode_a, anode_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic        fd_a, fd_b;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
        .anode(anode_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a)
    );

    seg_scan_driver #(.REFRESH_DIV(3), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
        .anode(anode_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b)
    );

    typedef struct packed {
        logic [12:0] a;
        logic [12:0] b;
    } exp_t;

    localparam logic [12:0] OFF = {4'b1111, 7'b1111111, 1'b1, 1'b0};

    localparam logic [6:0] SEG_TBL [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [15:0] VAL_TBL [0:4] = '{16'h0042, 16'h0000, 16'hC0DE, 16'h3679, 16'hB000};
    localparam logic [3:0]  DPM_TBL [0:4] = '{4'b0000, 4'b0001, 4'b1010, 4'b0100, 4'b1000};

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          k        = 0;
    logic [15:0] val_m    = '0;
    logic [3:0]  dpm_m    = '0;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got {anode,seg,dp,fd}=%b required %b", name, $time, act, req);
    endtask

    function automatic logic [6:0] seg_for(input logic [15:0] v, input int dig);
        logic [3:0] nib;
        logic [6:0] s;
        nib = v[dig*4 +: 4];
        s   = SEG_TBL[nib];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if (dig != 0 && (v >> (4*dig)) == 16'd0) s = 7'b1111111;
`endif
        return s;
    endfunction

    // Blanking instance: 4 SHOW cycles + 1 blank per digit, 20-cycle frame.
    function automatic logic [12:0] exp_a(input int kk, input logic [15:0] v, input logic [3:0] dm);
        int m;
        int dig;
        if (kk <= 0) return OFF;
        m = (kk - 1) % 20;
        if (m % 5 == 4) return {4'b1111, 7'b1111111, 1'b1, (m == 19)};
        dig = 3 - m / 5;
        return {~(4'b0001 << dig), seg_for(v, dig), ~dm[dig], 1'b0};
    endfunction

    // No-blanking instance: 3 SHOW cycles per digit, 12-cycle frame.
    function automatic logic [12:0] exp_b(input int kk, input logic [15:0] v, input logic [3:0] dm);
        int m;
        int dig;
        if (kk <= 0) return OFF;
        m   = (kk - 1) % 12;
        dig = 3 - m / 3;
        return {~(4'b0001 << dig), seg_for(v, dig), ~dm[dig], (m == 0 && kk > 1)};
    endfunction

    // k counts rising edges taken with reset low; inputs change 1 time unit after each edge.
    task automatic step(input logic rst_i, input logic ld_i, input logic [15:0] v_i, input logic [3:0] m_i);
        @(posedge clk);
        #1;
        if (reset) begin
            k = 0;
        end else begin
            k++;
            if (load) begin
                val_m = value;
                dpm_m = dp_mask;
            end
        end
        reset   = rst_i;
        load    = ld_i;
        value   = v_i;
        dp_mask = m_i;
        if (rst_i) begin
            k     = 0;
            val_m = '0;
            dpm_m = '0;
        end
        exp_q.push_back('{a: exp_a(k, val_m, dpm_m), b: exp_b(k, val_m, dpm_m)});
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("dut_a", {anode_a, seg_a, dp_a, fd_a}, mon_e.a);
                check("dut_b", {anode_b, seg_b, dp_b, fd_b}, mon_e.b);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset   = 1'b1;
        load    = 1'b0;
        value   = '0;
        dp_mask = '0;

        repeat (3) step(1'b1, 1'b0, 16'h0000, 4'b0000);
        repeat (8) step(1'b0, 1'b0, 16'h0000, 4'b0000);
        // Reset asserted mid-scan, then release together with a load.
        repeat (2) step(1'b1, 1'b0, 16'h0000, 4'b0000);
        step(1'b0, 1'b1, 16'h8F1A, 4'b0001);
        while (k < 46) step(1'b0, 1'b0, 16'h8F1A, 4'b0001);
        // Second cycle of digit 2's SHOW in the third frame.
        step(1'b0, 1'b1, 16'h0500, 4'b0001);
        repeat (30) step(1'b0, 1'b0, 16'h0500, 4'b0001);

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, VAL_TBL[i], DPM_TBL[i]);
            repeat (24) step(1'b0, 1'b0, VAL_TBL[i], DPM_TBL[i]);
        end

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream consumer of the ALU display path: latches a 16-bit result plus per-digit decimal-point mask and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Replaces four static 7-bit digit buses with one shared 7-bit segment bus plus 4 anode enables, scanned at a parameterised rate.
- Inserts an all-off blanking interval between digits to suppress ghosting.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is lit (SHOW length); legal range ≥1.
- BLANK_CYCLES, 500: clock cycles all anodes are off between digits; 0 disables blanking.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture strobe; samples value and dp_mask on this rising clk edge.
- value  input  16  result to display; value[15:12] is the leftmost digit.
- dp_mask  input  4  decimal point request per digit; bit i maps to anode[i]; 1 = point on.
- anode  output  4  active-low digit enables; anode[3] is leftmost, i.e. value[15:12].
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- frame_done  output  1  one-cycle pulse when digit 0's SHOW interval ends.

Behaviour:
- Reset (asynchronous, immediate):
  - anode=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
  - value_reg=0, dp_reg=0, digit=3, counter=0, state=BLANK.
- Holding registers: on a clk edge with load=1, value_reg<=value and dp_reg<=dp_mask. A load in any state is accepted. Effect on seg/dp is visible one cycle after the load edge, mid-digit if in SHOW.
- FSM states are BLANK and SHOW; counter counts 0..N-1 within a state, N being BLANK_CYCLES or REFRESH_DIV.
  - BLANK: anode=1111, seg=1111111, dp=1. At counter==BLANK_CYCLES-1, go to SHOW with counter<=0.
  - SHOW: anode has only bit [digit] low; seg is the decode of nibble value_reg[4*digit+3:4*digit]; dp=~dp_reg[digit].
  - At the end of SHOW (counter==REFRESH_DIV-1), digit<=digit-1, with 0 wrapping to 3. Next state is BLANK (or SHOW directly when BLANK_CYCLES=0) with counter<=0.
  - When BLANK_CYCLES=0, BLANK is entered only after reset, for zero cycles: the first SHOW starts the first cycle after reset deasserts.
- Scan order is 3,2,1,0 and repeats. Frame period = 4*(REFRESH_DIV+BLANK_CYCLES) cycles.
- frame_done is high for exactly the one cycle after the edge on which digit 0's SHOW ends, coincident with the first BLANK (or digit 3 SHOW) cycle.
- Output timing: anode, seg, dp and frame_done are driven directly from flops. There is no combinational path from any input to any output.
- Decode table (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-operation: all outputs return to reset values immediately. The scan restarts at digit 3 after BLANK once reset deasserts.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, a digit whose nibble is 0 and all of whose more-significant nibbles are 0 outputs seg=1111111 and dp=~dp_reg[digit]. Digit 0 is never blanked, so 0x0000 shows a single "0" and 0x0042 shows "  42". Anode timing is unchanged.
- Undefined: all four digits are always decoded, so 0x0042 shows "0042".

Test Plan:
- Reset check (REFRESH_DIV=4, BLANK_CYCLES=1): assert reset mid-cycle -> anode=1111, seg=1111111, dp=1, frame_done=0 immediately and while held. After release: 1 BLANK cycle, then anode=0111 with seg=1000000.
- Scan sequence: load value=0x8F1A, dp_mask=0001 -> repeating pattern, each digit held 4 cycles with a 1-cycle all-off gap:
  - anode 0111, seg 0000000
  - anode 1011, seg 0001110
  - anode 1101, seg 1111001
  - anode 1110, seg 0001000, dp=0 only here
  - Expected: frame_done pulses every 20 cycles.
- Load mid-digit: during the second cycle of digit 2's SHOW, load 0x0500 -> next cycle seg changes from the old nibble to 0010010 with anode still 1011. The SHOW length of that digit is still 4 cycles.
- Zero blanking (BLANK_CYCLES=0, REFRESH_DIV=3): after the first SHOW, anode is never 1111. Anode cycles 0111, 1011, 1101, 1110, each for 3 cycles, with frame_done every 12 cycles.
- Optional macro: with SEG_SCAN_LEADING_ZERO_BLANK_EN defined, load 0x0042 -> digits 3 and 2 show seg=1111111 while their anodes are active, digit 1 shows 0011001, digit 0 shows 0100100. Load 0x0000 -> only digit 0 shows 1000000. With the macro undefined, 0x0042 shows 1000000, 1000000, 0011001, 0100100.
